// File: rtl/gb_audio_mixer.sv
// N-channel stereo mixer: per-channel gain/mute, average or saturating-sum
// normalisation, time-multiplexed accumulation triggered by a sample strobe.
`timescale 1ns/1ps
module gb_audio_mixer #(
    parameter int NUM_CH = 2,
    parameter int W      = 16,
    parameter int GAIN_W = 4
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic                     ce,
    input  logic [NUM_CH*W-1:0]      ch_l,
    input  logic [NUM_CH*W-1:0]      ch_r,
    input  logic [NUM_CH*GAIN_W-1:0] ch_gain,
    input  logic [NUM_CH-1:0]        ch_mute,
    input  logic                     sum_mode,
    output logic [W-1:0]             audio_l,
    output logic [W-1:0]             audio_r,
    output logic                     sample_valid,
    output logic                     overrun
);

    localparam int ACC_W  = W + GAIN_W + $clog2(NUM_CH + 1);
    localparam int PROD_W = W + GAIN_W;
    localparam int AVG_SH = $clog2(NUM_CH);
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, SNAP, ACC, FINAL} state_t;

    state_t                    state, state_nxt;
    logic                      pending;
    logic [IDX_W-1:0]          idx;
    logic [NUM_CH*W-1:0]       sh_l, sh_r;
    logic [NUM_CH*GAIN_W-1:0]  sh_gain;
    logic [NUM_CH-1:0]         sh_mute;
    logic                      sh_mode;
    logic [ACC_W-1:0]          acc_l, acc_r;

    logic [W-1:0]              smp_l, smp_r;
    logic [GAIN_W-1:0]         gain;
    logic [PROD_W-1:0]         prod_l, prod_r, term_l, term_r;
    logic [ACC_W-1:0]          res_l, res_r;
    logic [W-1:0]              sat_l, sat_r;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ce) state_nxt = SNAP;
            SNAP:    state_nxt = ACC;
            ACC:     if (idx == LAST_IDX) state_nxt = FINAL;
            FINAL:   state_nxt = (pending || ce) ? SNAP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        smp_l  = sh_l[int'(idx)*W +: W];
        smp_r  = sh_r[int'(idx)*W +: W];
        gain   = sh_gain[int'(idx)*GAIN_W +: GAIN_W];
        prod_l = PROD_W'(smp_l) * PROD_W'(gain);
        prod_r = PROD_W'(smp_r) * PROD_W'(gain);
        term_l = sh_mute[idx] ? '0 : (prod_l >> (GAIN_W - 1));
        term_r = sh_mute[idx] ? '0 : (prod_r >> (GAIN_W - 1));
        res_l  = sh_mode ? acc_l : (acc_l >> AVG_SH);
        res_r  = sh_mode ? acc_r : (acc_r >> AVG_SH);
        sat_l  = (|res_l[ACC_W-1:W]) ? '1 : res_l[W-1:0];
        sat_r  = (|res_r[ACC_W-1:W]) ? '1 : res_r[W-1:0];
    end

    // A ce landing in FINAL is consumed by the direct FINAL->SNAP transition,
    // so FINAL's pending clear deliberately overrides the busy-strobe set.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pending      <= 1'b0;
            overrun      <= 1'b0;
            idx          <= '0;
            sh_l         <= '0;
            sh_r         <= '0;
            sh_gain      <= '0;
            sh_mute      <= '0;
            sh_mode      <= 1'b0;
            acc_l        <= '0;
            acc_r        <= '0;
            audio_l      <= '0;
            audio_r      <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (ce && state != IDLE) begin
                pending <= 1'b1;
                overrun <= 1'b1;
            end
            case (state)
                SNAP: begin
                    sh_l    <= ch_l;
                    sh_r    <= ch_r;
                    sh_gain <= ch_gain;
                    sh_mute <= ch_mute;
                    sh_mode <= sum_mode;
                    acc_l   <= '0;
                    acc_r   <= '0;
                    idx     <= '0;
                end
                ACC: begin
                    acc_l <= acc_l + ACC_W'(term_l);
                    acc_r <= acc_r + ACC_W'(term_r);
                    if (idx != LAST_IDX) idx <= idx + 1'b1;
                end
                FINAL: begin
                    audio_l      <= sat_l;
                    audio_r      <= sat_r;
                    sample_valid <= 1'b1;
                    pending      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
